// File: rtl/rpc2_ctrl_axi_master_address_channel_if.sv
// Command port plus AXI AW/AR address channels between issuer (master) and its environment (slave).
interface rpc2_ctrl_axi_master_address_channel_if #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_LEN_WIDTH  = 8
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_rw_n;
    logic [C_AXI_ID_WIDTH-1:0]   cmd_id;
    logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr;
    logic [C_AXI_LEN_WIDTH-1:0]  cmd_len;
    logic [2:0]                  cmd_size;
    logic [1:0]                  cmd_burst;

    logic [C_AXI_ID_WIDTH-1:0]   AXI_AWID;
    logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR;
    logic [C_AXI_LEN_WIDTH-1:0]  AXI_AWLEN;
    logic [2:0]                  AXI_AWSIZE;
    logic [1:0]                  AXI_AWBURST;
    logic                        AXI_AWVALID;
    logic                        AXI_AWREADY;

    logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID;
    logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR;
    logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN;
    logic [2:0]                  AXI_ARSIZE;
    logic [1:0]                  AXI_ARBURST;
    logic                        AXI_ARVALID;
    logic                        AXI_ARREADY;

    modport master (
        input  cmd_valid, cmd_rw_n, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output cmd_ready,
        output AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWVALID,
        input  AXI_AWREADY,
        output AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARVALID,
        input  AXI_ARREADY
    );

    modport slave (
        output cmd_valid, cmd_rw_n, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready,
        input  AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWVALID,
        output AXI_AWREADY,
        input  AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARVALID,
        output AXI_ARREADY
    );
endinterface

// File: rtl/rpc2_ctrl_axi_master_address_channel.sv
// AXI AW/AR issuer with per-direction outstanding throttling; AxVALID registered one cycle after accept.
// Backpressure: cmd_ready drops while the direction's slot is held by an unaccepted request or its counter is full.
module rpc2_ctrl_axi_master_address_channel #(
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_ADDR_WIDTH  = 32,
    parameter int C_AXI_LEN_WIDTH   = 8,
    parameter int C_MAX_OUTSTANDING = 4,
    parameter int C_CNT_WIDTH       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    rpc2_ctrl_axi_master_address_channel_if.master bus,
    input  logic                       wr_resp_done,
    input  logic                       rd_resp_done,
    output logic                       wdata_req,
    output logic [C_AXI_LEN_WIDTH-1:0] wdata_len,
    output logic [2:0]                 wdata_size,
    output logic [C_CNT_WIDTH-1:0]     wr_outstanding,
    output logic [C_CNT_WIDTH-1:0]     rd_outstanding,
    output logic                       cmd_err,
    output logic                       proto_err,
    output logic                       idle
);

    typedef struct packed {
        logic [C_AXI_ID_WIDTH-1:0]   id;
        logic [C_AXI_ADDR_WIDTH-1:0] addr;
        logic [C_AXI_LEN_WIDTH-1:0]  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
    } req_t;

    localparam logic [C_CNT_WIDTH-1:0] MAX_CNT = C_CNT_WIDTH'(C_MAX_OUTSTANDING);

    req_t                   cmd_req, aw_q, ar_q;
    logic                   aw_vld, ar_vld;
    logic [C_CNT_WIDTH-1:0] wr_cnt, rd_cnt;
    logic                   wrap_len_ok, illegal;
    logic                   wr_room, rd_room, cmd_rdy, accept, wr_acc, rd_acc;

    function automatic logic [C_CNT_WIDTH-1:0] cnt_next(input logic [C_CNT_WIDTH-1:0] cnt,
                                                        input logic inc, input logic done);
        logic dec;
        dec = done && (cnt != '0);
        case ({inc, dec})
            2'b10:   return cnt + C_CNT_WIDTH'(1);
            2'b01:   return cnt - C_CNT_WIDTH'(1);
            default: return cnt;
        endcase
    endfunction

    assign cmd_req = '{id: bus.cmd_id, addr: bus.cmd_addr, len: bus.cmd_len,
                       size: bus.cmd_size, burst: bus.cmd_burst};

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    assign wrap_len_ok = (bus.cmd_len == C_AXI_LEN_WIDTH'(1))  || (bus.cmd_len == C_AXI_LEN_WIDTH'(3)) ||
                         (bus.cmd_len == C_AXI_LEN_WIDTH'(7))  || (bus.cmd_len == C_AXI_LEN_WIDTH'(15));
    assign illegal     = (bus.cmd_burst == 2'b11) || ((bus.cmd_burst == 2'b10) && !wrap_len_ok);

    assign wr_room = (~aw_vld | bus.AXI_AWREADY) & (wr_cnt < MAX_CNT);
    assign rd_room = (~ar_vld | bus.AXI_ARREADY) & (rd_cnt < MAX_CNT);
    assign cmd_rdy = ~reset & (illegal | (bus.cmd_rw_n ? rd_room : wr_room));
    assign accept  = bus.cmd_valid & cmd_rdy;
    assign wr_acc  = accept & ~illegal & ~bus.cmd_rw_n;
    assign rd_acc  = accept & ~illegal &  bus.cmd_rw_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_q       <= '0;
            ar_q       <= '0;
            aw_vld     <= 1'b0;
            ar_vld     <= 1'b0;
            wdata_req  <= 1'b0;
            wdata_len  <= '0;
            wdata_size <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            cmd_err    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            // A new accept wins over the handshake so the slot reloads without a bubble.
            if (wr_acc) begin
                aw_q   <= cmd_req;
                aw_vld <= 1'b1;
            end else if (bus.AXI_AWREADY) begin
                aw_vld <= 1'b0;
            end
            if (rd_acc) begin
                ar_q   <= cmd_req;
                ar_vld <= 1'b1;
            end else if (bus.AXI_ARREADY) begin
                ar_vld <= 1'b0;
            end
            wdata_req <= wr_acc;
            if (wr_acc) begin
                wdata_len  <= bus.cmd_len;
                wdata_size <= bus.cmd_size;
            end
            cmd_err <= accept & illegal;
            wr_cnt  <= cnt_next(wr_cnt, wr_acc, wr_resp_done);
            rd_cnt  <= cnt_next(rd_cnt, rd_acc, rd_resp_done);
            if ((wr_resp_done && (wr_cnt == '0)) || (rd_resp_done && (rd_cnt == '0)))
                proto_err <= 1'b1;
        end
    end

    assign bus.cmd_ready   = cmd_rdy;
    assign bus.AXI_AWID    = aw_q.id;
    assign bus.AXI_AWADDR  = aw_q.addr;
    assign bus.AXI_AWLEN   = aw_q.len;
    assign bus.AXI_AWSIZE  = aw_q.size;
    assign bus.AXI_AWBURST = aw_q.burst;
    assign bus.AXI_AWVALID = aw_vld;
    assign bus.AXI_ARID    = ar_q.id;
    assign bus.AXI_ARADDR  = ar_q.addr;
    assign bus.AXI_ARLEN   = ar_q.len;
    assign bus.AXI_ARSIZE  = ar_q.size;
    assign bus.AXI_ARBURST = ar_q.burst;
    assign bus.AXI_ARVALID = ar_vld;

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;
    assign idle           = (wr_cnt == '0) && (rd_cnt == '0) && !aw_vld && !ar_vld;

endmodule

// File: tb/tb_rpc2_ctrl_axi_master_address_channel.sv
// Directed plus random stimulus against a transaction-level model of the address issuer.
module tb_rpc2_ctrl_axi_master_address_channel;
    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_resp_done, rd_resp_done;
    logic       wdata_req;
    logic [7:0] wdata_len;
    logic [2:0] wdata_size;
    logic [2:0] wr_outstanding, rd_outstanding;
    logic       cmd_err, proto_err, idle;

    always #5 clk = ~clk;

    rpc2_ctrl_axi_master_address_channel_if bus_if ();

    rpc2_ctrl_axi_master_address_channel dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .wr_resp_done  (wr_resp_done),
        .rd_resp_done  (rd_resp_done),
        .wdata_req     (wdata_req),
        .wdata_len     (wdata_len),
        .wdata_size    (wdata_size),
        .wr_outstanding(wr_outstanding),
        .rd_outstanding(rd_outstanding),
        .cmd_err       (cmd_err),
        .proto_err     (proto_err),
        .idle          (idle)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } req_t;

    // Model: requests accepted but not yet handshaken, plus in-flight transaction counts.
    req_t       awq[$], arq[$];
    int         wr_n, rd_n;
    bit         proto_m, err_m, wreq_m, rst_seen;
    logic [7:0] wlen_m;
    logic [2:0] wsize_m;
    int         n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] b, input logic [7:0] l);
        if (b == 2'b11) return 1'b0;
        if (b == 2'b10) return (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
        return 1'b1;
    endfunction

    function automatic bit exp_ready();
        if (reset) return 1'b0;
        if (!legal(bus_if.cmd_burst, bus_if.cmd_len)) return 1'b1;
        if (bus_if.cmd_rw_n) return (arq.size() == 0 || bus_if.AXI_ARREADY) && rd_n < MAXO;
        return (awq.size() == 0 || bus_if.AXI_AWREADY) && wr_n < MAXO;
    endfunction

    task automatic model_update();
        bit   acc, lg;
        req_t c;
        lg  = legal(bus_if.cmd_burst, bus_if.cmd_len);
        acc = bus_if.cmd_valid && exp_ready();
        c   = '{bus_if.cmd_id, bus_if.cmd_addr, bus_if.cmd_len, bus_if.cmd_size, bus_if.cmd_burst};
        if (reset) begin
            awq.delete(); arq.delete();
            wr_n = 0; rd_n = 0; proto_m = 0; err_m = 0; wreq_m = 0; rst_seen = 1;
            return;
        end
        rst_seen = 0;
        if (awq.size() > 0 && bus_if.AXI_AWREADY) void'(awq.pop_front());
        if (arq.size() > 0 && bus_if.AXI_ARREADY) void'(arq.pop_front());
        err_m  = acc && !lg;
        wreq_m = 0;
        if (wr_resp_done) begin if (wr_n == 0) proto_m = 1; else wr_n--; end
        if (rd_resp_done) begin if (rd_n == 0) proto_m = 1; else rd_n--; end
        if (acc && lg) begin
            if (!bus_if.cmd_rw_n) begin
                awq.push_back(c); wr_n++; wreq_m = 1; wlen_m = c.len; wsize_m = c.size;
            end else begin
                arq.push_back(c); rd_n++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("awvalid", bus_if.AXI_AWVALID, awq.size() > 0);
        if (awq.size() > 0)
            chk("aw_fields", {bus_if.AXI_AWID, bus_if.AXI_AWADDR, bus_if.AXI_AWLEN,
                              bus_if.AXI_AWSIZE, bus_if.AXI_AWBURST}, awq[0]);
        chk("arvalid", bus_if.AXI_ARVALID, arq.size() > 0);
        if (arq.size() > 0)
            chk("ar_fields", {bus_if.AXI_ARID, bus_if.AXI_ARADDR, bus_if.AXI_ARLEN,
                              bus_if.AXI_ARSIZE, bus_if.AXI_ARBURST}, arq[0]);
        chk("wdata_req", wdata_req, wreq_m);
        if (wreq_m) chk("wdata_len_size", {wdata_len, wdata_size}, {wlen_m, wsize_m});
        chk("wr_outstanding", wr_outstanding, wr_n);
        chk("rd_outstanding", rd_outstanding, rd_n);
        chk("cmd_err", cmd_err, err_m);
        chk("proto_err", proto_err, proto_m);
        chk("idle", idle, wr_n == 0 && rd_n == 0 && awq.size() == 0 && arq.size() == 0);
        if (rst_seen) begin
            chk("rst_aw_fields", {bus_if.AXI_AWID, bus_if.AXI_AWADDR, bus_if.AXI_AWLEN,
                                  bus_if.AXI_AWSIZE, bus_if.AXI_AWBURST}, 64'd0);
            chk("rst_ar_fields", {bus_if.AXI_ARID, bus_if.AXI_ARADDR, bus_if.AXI_ARLEN,
                                  bus_if.AXI_ARSIZE, bus_if.AXI_ARBURST}, 64'd0);
            chk("rst_wdata", {wdata_len, wdata_size}, 64'd0);
        end
    endtask

    // One clock: cmd_ready checked mid-cycle, registered outputs just after the edge.
    task automatic cycle();
        @(negedge clk);
        chk("cmd_ready", bus_if.cmd_ready, exp_ready());
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic set_cmd(input bit rw, input int id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_rw_n  = rw;
        bus_if.cmd_id    = 4'(id);
        bus_if.cmd_addr  = addr;
        bus_if.cmd_len   = 8'(len);
        bus_if.cmd_size  = 3'(size);
        bus_if.cmd_burst = burst;
    endtask

    task automatic drain();
        bus_if.cmd_valid   = 1'b0;
        bus_if.AXI_AWREADY = 1'b1;
        bus_if.AXI_ARREADY = 1'b1;
        for (int k = 0; k < 20 && (wr_n > 0 || rd_n > 0 || awq.size() > 0 || arq.size() > 0); k++) begin
            wr_resp_done = (wr_n > 0);
            rd_resp_done = (rd_n > 0);
            cycle();
        end
        wr_resp_done = 1'b0;
        rd_resp_done = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        wr_resp_done = 1'b0;
        rd_resp_done = 1'b0;
        bus_if.AXI_AWREADY = 1'b0;
        bus_if.AXI_ARREADY = 1'b0;
        set_cmd(0, 1, 32'h10, 0, 0, 2'b01);
        cycle();
        cycle();
        reset = 1'b0;
        bus_if.cmd_valid = 1'b0;
        cycle();

        // Single write with AWREADY tied high
        bus_if.AXI_AWREADY = 1'b1;
        set_cmd(0, 3, 32'h1000, 3, 2, 2'b01);
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t1_awaddr", bus_if.AXI_AWADDR, 32'h1000);
        chk("t1_wdata_len", wdata_len, 8'd3);
        chk("t1_wr_out", wr_outstanding, 3'd1);
        cycle();
        wr_resp_done = 1'b1;
        cycle();
        wr_resp_done = 1'b0;
        chk("t1_idle", idle, 1'b1);

        // AWREADY backpressure with a second write waiting
        bus_if.AXI_AWREADY = 1'b0;
        set_cmd(0, 5, 32'h2000, 0, 3, 2'b01);
        cycle();
        set_cmd(0, 6, 32'h3000, 7, 1, 2'b00);
        for (int k = 0; k < 5; k++) cycle();
        chk("t2_held_id", bus_if.AXI_AWID, 4'd5);
        bus_if.AXI_AWREADY = 1'b1;
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t2_reload_id", bus_if.AXI_AWID, 4'd6);
        chk("t2_reload_valid", bus_if.AXI_AWVALID, 1'b1);
        cycle();
        drain();

        // Read throttle at the outstanding limit
        bus_if.AXI_ARREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1, i, 32'h4000 + 32'(i * 64), 1, 2, 2'b01);
            cycle();
        end
        set_cmd(1, 4, 32'h4100, 1, 2, 2'b01);
        cycle();
        cycle();
        chk("t3_rd_out_full", rd_outstanding, 3'd4);
        chk("t3_blocked", bus_if.cmd_ready, 1'b0);
        rd_resp_done = 1'b1;
        cycle();
        rd_resp_done = 1'b0;
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t3_rd_out_after", rd_outstanding, 3'd4);
        chk("t3_arid", bus_if.AXI_ARID, 4'd4);
        cycle();
        drain();

        // Illegal encodings
        set_cmd(0, 1, 32'h5000, 3, 2, 2'b11);
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t4_err1", cmd_err, 1'b1);
        cycle();
        set_cmd(0, 2, 32'h5100, 2, 2, 2'b10);
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t4_err2", cmd_err, 1'b1);
        chk("t4_no_aw", bus_if.AXI_AWVALID, 1'b0);
        cycle();

        // Simultaneous accept/done, and direction independence
        bus_if.AXI_AWREADY = 1'b1;
        set_cmd(0, 7, 32'h6000, 0, 2, 2'b01);
        cycle();
        set_cmd(0, 8, 32'h6040, 15, 2, 2'b10);
        cycle();
        set_cmd(0, 9, 32'h6080, 1, 2, 2'b01);
        wr_resp_done = 1'b1;
        cycle();
        wr_resp_done = 1'b0;
        chk("t5_cnt_hold", wr_outstanding, 3'd2);
        bus_if.AXI_AWREADY = 1'b0;
        bus_if.AXI_ARREADY = 1'b1;
        set_cmd(1, 10, 32'h7000, 3, 3, 2'b01);
        cycle();
        bus_if.cmd_valid = 1'b0;
        chk("t5_ar_parallel", bus_if.AXI_ARVALID, 1'b1);
        chk("t5_aw_blocked", bus_if.AXI_AWVALID, 1'b1);
        cycle();
        drain();

        // Protocol error, then reset during a pending AW
        wr_resp_done = 1'b1;
        cycle();
        wr_resp_done = 1'b0;
        chk("t6_proto", proto_err, 1'b1);
        cycle();
        cycle();
        chk("t6_proto_sticky", proto_err, 1'b1);
        bus_if.AXI_AWREADY = 1'b0;
        set_cmd(0, 11, 32'h8000, 7, 2, 2'b01);
        cycle();
        bus_if.cmd_valid = 1'b0;
        reset = 1'b1;
        cycle();
        chk("t6_rst_proto", proto_err, 1'b0);
        chk("t6_rst_awvalid", bus_if.AXI_AWVALID, 1'b0);
        reset = 1'b0;
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int lsel;
            lsel = int'($urandom_range(0, 6));
            bus_if.cmd_valid = 1'($urandom_range(0, 1));
            bus_if.cmd_rw_n  = 1'($urandom_range(0, 1));
            bus_if.cmd_id    = 4'($urandom);
            bus_if.cmd_addr  = $urandom;
            case (lsel)
                0: bus_if.cmd_len = 8'd0;
                1: bus_if.cmd_len = 8'd1;
                2: bus_if.cmd_len = 8'd3;
                3: bus_if.cmd_len = 8'd7;
                4: bus_if.cmd_len = 8'd15;
                default: bus_if.cmd_len = 8'($urandom);
            endcase
            bus_if.cmd_size    = 3'($urandom);
            bus_if.cmd_burst   = 2'($urandom);
            bus_if.AXI_AWREADY = ($urandom_range(0, 2) != 0);
            bus_if.AXI_ARREADY = ($urandom_range(0, 2) != 0);
            wr_resp_done = (wr_n > 0) && ($urandom_range(0, 2) == 0);
            rd_resp_done = (rd_n > 0) && ($urandom_range(0, 2) == 0);
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rpc2_ctrl_axi_master_address_channel.md
Name: rpc2_ctrl_axi_master_address_channel

Overview:
AXI initiator-side address channel issuer, used by the controller's self-test/loopback master and by the bridge-to-memory path.
- Accepts packed commands on a valid/ready command port and drives registered AXI AW or AR requests.
- Tracks outstanding write and read transactions per direction and throttles command acceptance.
- Requests write-data generation for every issued write.
- Illegal burst encodings are rejected locally and never reach the bus.

Parameters:
C_AXI_ID_WIDTH, 4, AXI ID width
C_AXI_ADDR_WIDTH, 32, AXI address width
C_AXI_LEN_WIDTH, 8, AxLEN width
C_MAX_OUTSTANDING, 4, max in-flight transactions per direction (1..7)
C_CNT_WIDTH, 3, outstanding counter width; must hold C_MAX_OUTSTANDING

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted this cycle when cmd_valid=1
cmd_rw_n  in  1  1=read, 0=write
cmd_id  in  C_AXI_ID_WIDTH  transaction ID
cmd_addr  in  C_AXI_ADDR_WIDTH  start address
cmd_len  in  C_AXI_LEN_WIDTH  AxLEN (beats-1)
cmd_size  in  3  AxSIZE
cmd_burst  in  2  AxBURST
AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  as cmd_*  write address fields
AXI_AWVALID  out  1  write address valid
AXI_AWREADY  in  1  write address ready
AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  as cmd_*  read address fields
AXI_ARVALID  out  1  read address valid
AXI_ARREADY  in  1  read address ready
wr_resp_done  in  1  one-cycle pulse: a B response was consumed
rd_resp_done  in  1  one-cycle pulse: an RLAST beat was consumed
wdata_req  out  1  one-cycle pulse: start a write-data burst
wdata_len  out  C_AXI_LEN_WIDTH  beats-1 for that burst
wdata_size  out  3  beat size for that burst
wr_outstanding  out  C_CNT_WIDTH  in-flight write count
rd_outstanding  out  C_CNT_WIDTH  in-flight read count
cmd_err  out  1  one-cycle pulse: illegal command dropped
proto_err  out  1  sticky: resp_done received with its counter at 0
idle  out  1  both counters 0 and both xVALID low

Behaviour:
Reset (synchronous, active-high):
- All outputs 0: both xVALID, all AXI fields, wdata_*, both counters, both error flags.
- cmd_ready is also forced 0 while reset=1.
- Reset mid-burst drops any pending AW/AR without completing its handshake.

Legality:
- Illegal = burst 2'b11, or burst WRAP (2'b10) with len not in {1,3,7,15}.
- Illegal commands are checked before throttling: cmd_ready=1 regardless of slot and counter state.
- On acceptance: cmd_err pulses the next cycle. No AXI request, no counter change, no wdata_req.

Acceptance (legal commands, cmd_ready is combinational):
- Write: wr_slot_free & (wr_outstanding < C_MAX_OUTSTANDING), where wr_slot_free = ~AXI_AWVALID | AXI_AWREADY.
- Read: same rule with AR signals and rd_outstanding.
- cmd_ready depends only on cmd_rw_n, the legality check and internal state, never on cmd_valid.
- The AWREADY/ARREADY-to-cmd_ready path is combinational, so back-to-back issue runs at one command per cycle.

Issue:
- On accept, the AXI fields and xVALID are registered the next cycle (latency 1).
- xVALID stays high with fields stable until xREADY=1 sampled high.
- An accept in the same cycle as the xREADY handshake reloads the register, so xVALID stays high with the new fields.
- AW and AR are independent. A read may reach the bus before an earlier-accepted write. No ordering between directions is guaranteed.

Write-data request:
- Each accepted legal write pulses wdata_req in the same cycle AXI_AWVALID first rises, with wdata_len=cmd_len and wdata_size=cmd_size.
- It fires once per write, independent of AWREADY.

Counters:
- Increment on accept, decrement on the matching resp_done. Simultaneous accept and done leaves the count unchanged.
- A done with the count at 0 holds the count at 0 and sets proto_err, which stays set until reset.
- A counter can never exceed C_MAX_OUTSTANDING. At the limit, cmd_ready for that direction is 0 until a done arrives.
- A done that arrives while the counter is at its limit frees a slot for acceptance in the next cycle, not the same cycle.

idle:
- Combinational from the counters and both xVALIDs.

Test Plan:
1. Single write: id=3, addr=0x1000, len=3, size=2, INCR, AWREADY tied high -> AWVALID high for 1 cycle with those fields; wdata_req with len=3; wr_outstanding=1; after wr_resp_done -> 0 and idle=1.
2. Backpressure: AWREADY low for 5 cycles -> AWVALID and fields stable; a second write is not accepted until the AWREADY cycle, then AWVALID stays high carrying the second command.
3. Throttle: 5 reads with ARREADY high, C_MAX_OUTSTANDING=4 -> 4 accepted, cmd_ready=0 for the 5th; rd_resp_done -> 5th accepted the following cycle; rd_outstanding stays at 4.
4. Illegal commands: burst=2'b11, then WRAP with len=2 -> each accepted; cmd_err pulses; no AWVALID, no wdata_req, counters 0.
5. Simultaneous events and independence: accept a write and wr_resp_done in the same cycle with count 2 -> count stays 2. With the AW slot blocked (AWREADY low), a read issued in parallel still gets ARVALID.
6. Protocol error and reset: wr_resp_done at count 0 -> proto_err=1 and stays set. Assert reset while AWVALID is pending -> all outputs 0 the next cycle, proto_err cleared.
